// File: rtl/sdnet_mtpsa_pkg.sv
// Shared constants for the SDNet-to-SUME egress tuple re-attach block.
// Tuple layout is {digest, metadata}; metadata field offsets follow the SUME tuser map.
package sdnet_mtpsa_pkg;

  localparam int META_WIDTH   = 40;
  localparam int DIGEST_WIDTH = 256;
  localparam int TUPLE_WIDTH  = DIGEST_WIDTH + META_WIDTH;

  localparam logic [0:0] ST_SOP  = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  localparam int PKT_LEN_LSB  = 0;
  localparam int PKT_LEN_MSB  = 15;
  localparam int SRC_PORT_LSB = 16;
  localparam int SRC_PORT_MSB = 23;
  localparam int DST_PORT_LSB = 24;
  localparam int DST_PORT_MSB = 31;
  localparam int SEND_DIG_LSB = 32;
  localparam int SEND_DIG_MSB = 39;

endpackage

// File: rtl/tuple_fifo.sv
// Synchronous tuple FIFO; write at N is visible at head at N+1, no bypass.
// Push while full is dropped unless a pop happens in the same cycle.
module tuple_fifo #(
  parameter int WIDTH = 296,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sdnet_to_mtpsa.sv
// Re-attaches buffered SDNet tuples to the first beat of each egress packet; zero-latency data pass-through.
// Backpressure: first beat stalls (tvalid/tready low) until its tuple is queued; otherwise tready follows m_axis_tready.
module sdnet_to_mtpsa #(
  parameter int C_AXIS_DATA_WIDTH    = 256,
  parameter int META_WIDTH           = 40,
  parameter int DIGEST_WIDTH         = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 296,
  parameter int TUPLE_FIFO_DEPTH     = 4
) (
  input  logic                              axis_aclk,
  input  logic                              axis_rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              meta_tuple_VALID,
  input  logic [META_WIDTH-1:0]             meta_tuple_DATA,
  input  logic                              digest_tuple_VALID,
  input  logic [DIGEST_WIDTH-1:0]           digest_tuple_DATA,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       pkt_cnt,
  output logic [15:0]                       tuple_ovf_cnt,
  output logic                              tuple_ovf,
  output logic                              valid_mismatch
);
  import sdnet_mtpsa_pkg::*;

  localparam int TUPLE_W = DIGEST_WIDTH + META_WIDTH;

  logic [0:0]         state;
  logic               in_sop;
  logic               s_hs;
  logic               tuple_pop;
  logic               tuple_drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [TUPLE_W-1:0] fifo_head;

  tuple_fifo #(
    .WIDTH (TUPLE_W),
    .DEPTH (TUPLE_FIFO_DEPTH)
  ) u_tuple_fifo (
    .clk   (axis_aclk),
    .rst   (axis_rst),
    .push  (meta_tuple_VALID),
    .pop   (tuple_pop),
    .din   ({digest_tuple_DATA, meta_tuple_DATA}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_sop = (state == ST_SOP);

  // Empty-FIFO gating only applies at SOP, so a raised tvalid can never be withdrawn.
  assign s_axis_tready = in_sop ? (m_axis_tready & ~fifo_empty) : m_axis_tready;
  assign m_axis_tvalid = in_sop ? (s_axis_tvalid & ~fifo_empty) : s_axis_tvalid;
  assign m_axis_tuser  = in_sop ? C_M_AXIS_TUSER_WIDTH'(fifo_head) : '0;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;

  assign s_hs       = s_axis_tvalid & s_axis_tready;
  assign tuple_pop  = in_sop & s_hs;
  assign tuple_drop = meta_tuple_VALID & fifo_full & ~tuple_pop;

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state          <= ST_SOP;
      pkt_cnt        <= '0;
      tuple_ovf_cnt  <= '0;
      tuple_ovf      <= 1'b0;
      valid_mismatch <= 1'b0;
    end else begin
      if (s_hs) begin
        if (s_axis_tlast) begin
          state   <= ST_SOP;
          pkt_cnt <= pkt_cnt + 32'd1;
        end else begin
          state   <= ST_BODY;
        end
      end
      if (tuple_drop) begin
        tuple_ovf <= 1'b1;
        if (tuple_ovf_cnt != 16'hFFFF) tuple_ovf_cnt <= tuple_ovf_cnt + 16'd1;
      end
      if (meta_tuple_VALID != digest_tuple_VALID) valid_mismatch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdnet_to_mtpsa.sv
// Bench for sdnet_to_mtpsa: directed scenarios plus a randomized stream against a queue-based model.
module tb_sdnet_to_mtpsa;

  logic          axis_aclk = 1'b0;
  logic          axis_rst;
  logic [255:0]  s_axis_tdata;
  logic [31:0]   s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          meta_tuple_VALID;
  logic [39:0]   meta_tuple_DATA;
  logic          digest_tuple_VALID;
  logic [255:0]  digest_tuple_DATA;
  logic [255:0]  m_axis_tdata;
  logic [31:0]   m_axis_tkeep;
  logic [295:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [31:0]   pkt_cnt;
  logic [15:0]   tuple_ovf_cnt;
  logic          tuple_ovf;
  logic          valid_mismatch;

  always #5 axis_aclk = ~axis_aclk;

  sdnet_to_mtpsa dut (
    .axis_aclk          (axis_aclk),
    .axis_rst           (axis_rst),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tkeep       (s_axis_tkeep),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .meta_tuple_VALID   (meta_tuple_VALID),
    .meta_tuple_DATA    (meta_tuple_DATA),
    .digest_tuple_VALID (digest_tuple_VALID),
    .digest_tuple_DATA  (digest_tuple_DATA),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tuser       (m_axis_tuser),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .pkt_cnt            (pkt_cnt),
    .tuple_ovf_cnt      (tuple_ovf_cnt),
    .tuple_ovf          (tuple_ovf),
    .valid_mismatch     (valid_mismatch)
  );

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
    logic [295:0] u;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  bit    abort  = 0;
  int    cyc_n  = 0;
  int    started = 0;
  bit    mon_sop = 1;
  beat_t out_q[$];
  int    out_cyc[$];
  beat_t exp_q[$];

  always @(posedge axis_aclk) cyc_n = cyc_n + 1;

  // Records every output handshake; mid-cycle sample while inputs are stable.
  always @(negedge axis_aclk) begin
    if (!axis_rst && m_axis_tvalid && m_axis_tready) begin
      out_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
      out_cyc.push_back(cyc_n);
      if (mon_sop) started = started + 1;
      mon_sop = m_axis_tlast;
    end
  end

  task automatic cyc();
    @(posedge axis_aclk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_tuple(input logic [255:0] dg, input logic [39:0] mt, input logic dvld);
    meta_tuple_VALID   = 1'b1;
    digest_tuple_VALID = dvld;
    meta_tuple_DATA    = mt;
    digest_tuple_DATA  = dg;
    cyc();
    meta_tuple_VALID   = 1'b0;
    digest_tuple_VALID = 1'b0;
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
    int  w = 0;
    bit  done = 0;
    if (abort) return;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge axis_aclk);
      if (s_axis_tready) begin
        done = 1;
      end else if (w >= 100) begin
        checks++; errors++;
        $display("FAIL send_beat_timeout: beat not accepted after %0d cycles (required accept)", w);
        abort = 1;
        done  = 1;
      end
      w++;
      @(posedge axis_aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic compare_stream(input string name);
    checks++;
    if (out_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_beat%0d: got d=%h l=%b u=%h required d=%h l=%b u=%h", name, i,
                 out_q[i].d, out_q[i].l, out_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u);
      end
    end
  endtask

  task automatic test_reset();
    axis_rst = 1'b1;
    repeat (3) cyc();
    axis_rst = 1'b0;
    cyc();
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge axis_aclk);
    checks++;
    if ({m_axis_tvalid, s_axis_tready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_gating: tvalid/tready=%b required 00", {m_axis_tvalid, s_axis_tready});
    end
    checks++;
    if ({pkt_cnt, tuple_ovf_cnt, tuple_ovf, valid_mismatch} !== 50'd0) begin
      errors++;
      $display("FAIL reset_counters: pkt=%0d ovfcnt=%0d ovf=%b mm=%b required all 0",
               pkt_cnt, tuple_ovf_cnt, tuple_ovf, valid_mismatch);
    end
    cyc();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_basic();
    logic [255:0] dg = {32{8'hAB}};
    logic [39:0]  mt = 40'h00_04_01_0040;
    out_q.delete(); out_cyc.delete(); exp_q.delete();
    push_tuple(dg, mt, 1'b1);
    for (int b = 0; b < 3; b++) begin
      logic [255:0] d = rnd256();
      logic [31:0]  k = $urandom;
      exp_q.push_back('{d, k, (b == 2), (b == 0) ? {dg, mt} : 296'd0});
      send_beat(d, k, b == 2);
    end
    cyc();
    compare_stream("basic");
    checks++;
    if (out_cyc.size() != 3 || out_cyc[1] != out_cyc[0] + 1 || out_cyc[2] != out_cyc[1] + 1) begin
      errors++;
      $display("FAIL basic_bubbles: beat cycles not consecutive (got %0d beats) required 3 consecutive", out_cyc.size());
    end
    checks++;
    if (pkt_cnt !== 32'd1) begin
      errors++;
      $display("FAIL basic_pkt_cnt: got %0d required 1", pkt_cnt);
    end
  endtask

  task automatic test_tuple_late();
    logic [255:0] dg = rnd256();
    logic [39:0]  mt = {$urandom, 8'h5A};
    logic [255:0] d  = rnd256();
    out_q.delete(); out_cyc.delete();
    s_axis_tdata = d; s_axis_tkeep = '1; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge axis_aclk);
      checks++;
      if ({m_axis_tvalid, s_axis_tready} !== 2'b00) begin
        errors++;
        $display("FAIL late_stall_c%0d: tvalid/tready=%b required 00", c, {m_axis_tvalid, s_axis_tready});
      end
      cyc();
    end
    meta_tuple_VALID = 1'b1; digest_tuple_VALID = 1'b1; meta_tuple_DATA = mt; digest_tuple_DATA = dg;
    @(negedge axis_aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL late_no_bypass: tvalid=%b in push cycle required 0", m_axis_tvalid);
    end
    cyc();
    meta_tuple_VALID = 1'b0; digest_tuple_VALID = 1'b0;
    @(negedge axis_aclk);
    checks++;
    if ({m_axis_tvalid, s_axis_tready, m_axis_tuser} !== {2'b11, dg, mt}) begin
      errors++;
      $display("FAIL late_release: tvalid/tready=%b user=%h required 11 user=%h",
               {m_axis_tvalid, s_axis_tready}, m_axis_tuser, {dg, mt});
    end
    cyc();
    s_axis_tvalid = 1'b0;
    cyc();
    checks++;
    if (pkt_cnt !== 32'd2 || out_q.size() != 1) begin
      errors++;
      $display("FAIL late_pkt_cnt: pkt=%0d beats=%0d required pkt=2 beats=1", pkt_cnt, out_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [255:0] dg [5];
    logic [39:0]  mt [5];
    out_q.delete(); out_cyc.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      dg[i] = rnd256();
      mt[i] = {8'(i), $urandom};
    end
    meta_tuple_VALID = 1'b1; digest_tuple_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      meta_tuple_DATA = mt[i]; digest_tuple_DATA = dg[i];
      cyc();
    end
    meta_tuple_VALID = 1'b0; digest_tuple_VALID = 1'b0;
    checks++;
    if ({tuple_ovf, tuple_ovf_cnt} !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL ovf_flag: ovf=%b cnt=%0d required ovf=1 cnt=1", tuple_ovf, tuple_ovf_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      logic [255:0] d = rnd256();
      exp_q.push_back('{d, 32'hFFFF_FFFF, 1'b1, {dg[i], mt[i]}});
      send_beat(d, 32'hFFFF_FFFF, 1'b1);
    end
    cyc();
    compare_stream("ovf");
    checks++;
    if (pkt_cnt !== 32'd6 || valid_mismatch !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pkt_cnt: pkt=%0d mm=%b required pkt=6 mm=0", pkt_cnt, valid_mismatch);
    end
  endtask

  task automatic test_random_stream();
    localparam int NPKT = 100;
    logic [295:0] tup [NPKT];
    int  base_started;
    int  base_pkt;
    bit  stop = 0;
    out_q.delete(); out_cyc.delete(); exp_q.delete();
    base_started = started;
    base_pkt     = pkt_cnt;
    for (int i = 0; i < NPKT; i++) tup[i] = {rnd256(), $urandom, 8'($urandom)};
    fork
      begin
        for (int i = 0; i < NPKT && !abort; i++) begin
          int w = 0;
          while (i >= started - base_started + 3 && w < 2000 && !abort) begin
            cyc();
            w++;
          end
          repeat ($urandom_range(0, 3)) cyc();
          push_tuple(tup[i][295:40], tup[i][39:0], 1'b1);
        end
      end
      begin
        for (int i = 0; i < NPKT && !abort; i++) begin
          int nb = $urandom_range(1, 8);
          repeat ($urandom_range(0, 2)) cyc();
          for (int b = 0; b < nb; b++) begin
            logic [255:0] d = rnd256();
            logic [31:0]  k = $urandom;
            exp_q.push_back('{d, k, (b == nb - 1), (b == 0) ? tup[i] : 296'd0});
            send_beat(d, k, b == nb - 1);
          end
        end
        stop = 1;
      end
      begin
        while (!stop) begin
          m_axis_tready = 1'($urandom_range(0, 1));
          cyc();
        end
        m_axis_tready = 1'b1;
      end
    join
    cyc();
    compare_stream("rand");
    checks++;
    if (pkt_cnt - base_pkt !== 100 || tuple_ovf_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rand_counts: pkt delta=%0d ovfcnt=%0d required 100 and 1", pkt_cnt - base_pkt, tuple_ovf_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    push_tuple(rnd256(), 40'h1, 1'b1);
    send_beat(rnd256(), '1, 1'b0);
    push_tuple(rnd256(), 40'h2, 1'b1);
    push_tuple(rnd256(), 40'h3, 1'b1);
    axis_rst      = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    cyc();
    axis_rst = 1'b0;
    mon_sop  = 1;
    @(negedge axis_aclk);
    checks++;
    if ({m_axis_tvalid, s_axis_tready} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_gating: tvalid/tready=%b required 00", {m_axis_tvalid, s_axis_tready});
    end
    checks++;
    if ({pkt_cnt, tuple_ovf_cnt, tuple_ovf, valid_mismatch} !== 50'd0) begin
      errors++;
      $display("FAIL midrst_counters: pkt=%0d ovfcnt=%0d ovf=%b mm=%b required all 0",
               pkt_cnt, tuple_ovf_cnt, tuple_ovf, valid_mismatch);
    end
    cyc();
    s_axis_tvalid = 1'b0;
    cyc();
  endtask

  task automatic test_valid_mismatch();
    logic [255:0] dg = rnd256();
    logic [39:0]  mt = 40'hC0_FF_EE_1234;
    logic [255:0] d  = rnd256();
    out_q.delete(); out_cyc.delete(); exp_q.delete();
    push_tuple(dg, mt, 1'b0);
    repeat (3) cyc();
    checks++;
    if (valid_mismatch !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_sticky: valid_mismatch=%b required 1", valid_mismatch);
    end
    exp_q.push_back('{d, 32'h0000_00FF, 1'b1, {dg, mt}});
    send_beat(d, 32'h0000_00FF, 1'b1);
    cyc();
    compare_stream("mismatch");
    checks++;
    if (pkt_cnt !== 32'd1 || valid_mismatch !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_after: pkt=%0d mm=%b required pkt=1 mm=1", pkt_cnt, valid_mismatch);
    end
  endtask

  initial begin
    axis_rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    meta_tuple_VALID = 1'b0; meta_tuple_DATA = '0;
    digest_tuple_VALID = 1'b0; digest_tuple_DATA = '0;
    m_axis_tready = 1'b1;
    test_reset();
    test_basic();
    test_tuple_late();
    test_overflow();
    test_random_stream();
    test_reset_mid_packet();
    test_valid_mismatch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdnet_to_mtpsa.md
Name: sdnet_to_mtpsa

Overview:
Egress-side companion to the ingress tuple/TLAST converter. It sits between the SDNet user switch packet_out/tuple_out ports and the SUME AXI-Stream master.
- Buffers each SDNet output tuple ({digest_data, mtpsa_metadata}) in a small FIFO.
- Re-attaches the buffered tuple to the first beat of the matching output packet. tuser is all-zero on later beats.
- Stalls the packet stream until that packet's tuple is available.
- Counts forwarded packets and tuple overflows for the register block.

Parameters:
C_AXIS_DATA_WIDTH, 256, packet data width (tkeep = /8)
META_WIDTH, 40, mtpsa_metadata tuple width
DIGEST_WIDTH, 256, digest_data tuple width
C_M_AXIS_TUSER_WIDTH, 296, output tuser width; must equal DIGEST_WIDTH+META_WIDTH
TUPLE_FIFO_DEPTH, 4, tuple FIFO entries; power of 2, >=2

Ports:
axis_aclk  in  1  single clock for all logic
axis_rst  in  1  synchronous, active-high reset
s_axis_tdata  in  C_AXIS_DATA_WIDTH  SDNet packet_out data
s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  byte enables
s_axis_tvalid  in  1  SDNet packet_out valid
s_axis_tready  out  1  to SDNet packet_out TREADY
s_axis_tlast  in  1  end of packet
meta_tuple_VALID  in  1  SDNet tuple_out_mtpsa_metadata_VALID, one-cycle pulse
meta_tuple_DATA  in  META_WIDTH  metadata tuple
digest_tuple_VALID  in  1  digest VALID; monitored only
digest_tuple_DATA  in  DIGEST_WIDTH  digest tuple, captured with meta VALID
m_axis_tdata  out  C_AXIS_DATA_WIDTH  to SUME
m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  to SUME
m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  {digest, metadata} on first beat, 0 otherwise
m_axis_tvalid  out  1  to SUME
m_axis_tready  in  1  from SUME
m_axis_tlast  out  1  to SUME
pkt_cnt  out  32  packets forwarded (tlast handshakes), wraps
tuple_ovf_cnt  out  16  tuples dropped on full FIFO, saturates at 0xFFFF
tuple_ovf  out  1  sticky overflow flag; cleared only by reset
valid_mismatch  out  1  sticky; set when meta VALID != digest VALID in any cycle

Behaviour:
- Reset (sync, active-high):
  - FIFO empty, pointers 0; FSM = SOP.
  - pkt_cnt, tuple_ovf_cnt, tuple_ovf and valid_mismatch all 0.
  - m_axis_tvalid and s_axis_tready are 0 while FIFO is empty.
  - Reset mid-packet: remaining beats of the old packet are treated as a new packet. The SDNet block is reset from the same source, so this case is not otherwise handled.
- Tuple FIFO:
  - Push on meta_tuple_VALID, entry = {digest_tuple_DATA, meta_tuple_DATA}.
  - Write at cycle N; entry visible at head at N+1. No same-cycle bypass.
  - Full with no pop: entry dropped, tuple_ovf_cnt++ (saturating), tuple_ovf=1.
  - Full with a pop in the same cycle: both succeed; count stays full.
  - Pointers have log2(DEPTH)+1 bits; the extra bit distinguishes full from empty and wraps naturally.
- Datapath: tdata, tkeep and tlast are combinational pass-through. Zero added latency; no data storage.
- FSM state SOP (waiting for first beat):
  - s_axis_tready = m_axis_tready & !empty.
  - m_axis_tvalid = s_axis_tvalid & !empty.
  - m_axis_tuser = FIFO head.
  - On handshake (s_axis_tvalid & s_axis_tready): pop.
    - tlast=1: pkt_cnt++, stay SOP (single-beat packet).
    - else go to BODY.
- FSM state BODY:
  - s_axis_tready = m_axis_tready; m_axis_tvalid = s_axis_tvalid; m_axis_tuser = 0.
  - tlast handshake: pkt_cnt++, go to SOP. The FIFO is ignored for gating.
- AXIS rules:
  - m_axis_tvalid never depends on m_axis_tready.
  - Once asserted, m_axis_tvalid holds with stable data until handshake, given SDNet obeys AXIS. Gating on FIFO empty affects SOP only; the FIFO cannot drain while in SOP with valid high.
- Tuple arriving in the same cycle as the first beat: that beat stalls one cycle, then proceeds.

Decomposition:
- Package sdnet_mtpsa_pkg:
  - META_WIDTH, DIGEST_WIDTH, TUPLE_WIDTH.
  - FSM state enum {SOP, BODY}.
  - tuser field offsets: PKT_LEN[15:0], SRC_PORT[23:16], DST_PORT[31:24], SEND_DIG[39:32].
- One sub-module: tuple_fifo (sync FIFO; width/depth params; push, pop, head, full, empty).

Test Plan:
1. Tuple meta=0x00_04_01_0040 with digest=0xAB..AB, then a 3-beat packet, tready=1 -> beat0 tuser={0xAB..AB,0x0004010040}, beats 1-2 tuser=0, pkt_cnt=1, no bubbles.
2. Packet beat presented 5 cycles before its tuple -> m_axis_tvalid=0 and s_axis_tready=0 for 5 cycles, beat0 out in the cycle after the tuple push.
3. Five tuples pushed back-to-back with no packets, depth 4 -> 5th dropped, tuple_ovf=1, tuple_ovf_cnt=1. Then four 1-beat packets emit tuples 1-4 in order and pkt_cnt=4.
4. Random m_axis_tready (50%) over 100 packets of 1-8 beats -> output stream equals input stream, each beat0 tuser matches its tuple in order, pkt_cnt=100.
5. Assert axis_rst in BODY of a packet with 2 tuples queued -> next cycle FIFO empty, FSM=SOP, all counters and flags 0, m_axis_tvalid=0.
6. meta VALID pulsed without digest VALID -> valid_mismatch=1 (sticky) and the tuple is still enqueued.
